// File: rtl/matmul_operand_loader.sv
// rtl/matmul_operand_loader.sv - stages streamed operand words into top/left matrix buses for workflow_control
// Optional ping-pong operand banks when LOADER_DOUBLE_BUFFER_EN is defined.
module matmul_operand_loader #(
  parameter int WORD_SIZE = 16,
  parameter int ROWS      = 4,
  parameter int COLS      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WORD_SIZE-1:0]            in_data,
  output logic [ROWS*COLS*WORD_SIZE-1:0]  top_matrix,
  output logic [ROWS*COLS*WORD_SIZE-1:0]  left_matrix,
  output logic                            mat_valid,
  input  logic                            mat_ack,
  output logic                            loading_left
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    LOAD_TOP  = 2'd0,
    LOAD_LEFT = 2'd1,
    FULL      = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] idx;
  logic          xfer;
  logic          last_word;
  logic          fill_done;
  logic          release_set;
  logic          next_bank_busy;

  assign in_ready     = (state != FULL);
  assign loading_left = (state == LOAD_LEFT);
  assign xfer         = in_valid && in_ready;
  assign last_word    = (idx == IW'(N - 1));
  assign fill_done    = xfer && (state == LOAD_LEFT) && last_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_TOP;
      idx   <= '0;
    end else begin
      state <= state_next;
      if (xfer) begin
        idx <= last_word ? '0 : idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD_TOP: begin
        if (xfer && last_word) state_next = LOAD_LEFT;
      end
      LOAD_LEFT: begin
        // After a completed set, only stall if the bank we would write next is still owned by the reader.
        if (fill_done) state_next = next_bank_busy ? FULL : LOAD_TOP;
      end
      FULL: begin
        if (release_set) state_next = LOAD_TOP;
      end
      default: state_next = LOAD_TOP;
    endcase
  end

`ifdef LOADER_DOUBLE_BUFFER_EN
  logic [WORD_SIZE-1:0] top_mem  [2][N];
  logic [WORD_SIZE-1:0] left_mem [2][N];
  logic [1:0]           full;
  logic                 wr_bank;
  logic                 rd_bank;
  logic                 wr_bank_nxt;

  assign wr_bank_nxt    = ~wr_bank;
  assign release_set    = mat_ack && full[rd_bank];
  assign next_bank_busy = full[wr_bank_nxt] && !(release_set && (rd_bank == wr_bank_nxt));
  assign mat_valid      = full[rd_bank];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          top_mem[b][i]  <= '0;
          left_mem[b][i] <= '0;
        end
      end
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (xfer && (state == LOAD_TOP))  top_mem[wr_bank][idx]  <= in_data;
      if (xfer && (state == LOAD_LEFT)) left_mem[wr_bank][idx] <= in_data;
      // Fill and release always target different banks, so both may land in one cycle.
      if (fill_done) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= wr_bank_nxt;
      end
      if (release_set) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  always_comb begin
    top_matrix  = '0;
    left_matrix = '0;
    for (int i = 0; i < N; i++) begin
      top_matrix[i*WORD_SIZE +: WORD_SIZE]  = top_mem[rd_bank][i];
      left_matrix[i*WORD_SIZE +: WORD_SIZE] = left_mem[rd_bank][i];
    end
  end
`else
  logic [WORD_SIZE-1:0] top_mem  [N];
  logic [WORD_SIZE-1:0] left_mem [N];
  logic                 full;

  assign release_set    = mat_ack && full;
  assign next_bank_busy = 1'b1;
  assign mat_valid      = full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        top_mem[i]  <= '0;
        left_mem[i] <= '0;
      end
      full <= 1'b0;
    end else begin
      if (xfer && (state == LOAD_TOP))  top_mem[idx]  <= in_data;
      if (xfer && (state == LOAD_LEFT)) left_mem[idx] <= in_data;
      if (fill_done) begin
        full <= 1'b1;
      end else if (release_set) begin
        full <= 1'b0;
      end
    end
  end

  always_comb begin
    top_matrix  = '0;
    left_matrix = '0;
    for (int i = 0; i < N; i++) begin
      top_matrix[i*WORD_SIZE +: WORD_SIZE]  = top_mem[i];
      left_matrix[i*WORD_SIZE +: WORD_SIZE] = left_mem[i];
    end
  end
`endif

endmodule

// File: tb/tb_matmul_operand_loader.sv
// tb/tb_matmul_operand_loader.sv - self-checking bench for matmul_operand_loader against a set-queue model
module tb_matmul_operand_loader;

  localparam int W  = 16;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int N  = R * C;
  localparam int MW = N * W;
`ifdef LOADER_DOUBLE_BUFFER_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [MW-1:0] top_matrix;
  logic [MW-1:0] left_matrix;
  logic          mat_valid;
  logic          mat_ack;
  logic          loading_left;

  int compared   = 0;
  int mismatched = 0;

  // Model: words of the set being streamed, plus completed sets awaiting ack (oldest first).
  logic [W-1:0]  part[$];
  logic [MW-1:0] q_top[$];
  logic [MW-1:0] q_left[$];

  matmul_operand_loader #(.WORD_SIZE(W), .ROWS(R), .COLS(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .top_matrix   (top_matrix),
    .left_matrix  (left_matrix),
    .mat_valid    (mat_valid),
    .mat_ack      (mat_ack),
    .loading_left (loading_left)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] el(input logic [MW-1:0] m, input int i);
    return m[i*W +: W];
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk1("in_ready", in_ready, q_top.size() < NB);
    chk1("mat_valid", mat_valid, q_top.size() > 0);
    chk1("loading_left", loading_left, part.size() >= N);
    if (q_top.size() > 0) begin
      chkv("top_matrix", top_matrix, q_top[0]);
      chkv("left_matrix", left_matrix, q_left[0]);
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic a);
    logic          acc;
    logic          rel;
    logic [MW-1:0] t;
    logic [MW-1:0] l;
    in_valid = v;
    in_data  = d;
    mat_ack  = a;
    acc = v && (q_top.size() < NB);
    rel = a && (q_top.size() > 0);
    @(posedge clk);
    #1;
    if (acc) begin
      part.push_back(d);
      if (part.size() == 2 * N) begin
        for (int i = 0; i < N; i++) begin
          t[i*W +: W] = part[i];
          l[i*W +: W] = part[N + i];
        end
        q_top.push_back(t);
        q_left.push_back(l);
        part.delete();
      end
    end
    if (rel) begin
      void'(q_top.pop_front());
      void'(q_left.pop_front());
    end
    in_valid = 1'b0;
    mat_ack  = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    mat_ack  = 1'b0;
    #2;
    part.delete();
    q_top.delete();
    q_left.delete();
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_mat_valid", mat_valid, 1'b0);
    chk1("rst_loading_left", loading_left, 1'b0);
    chkv("rst_top", top_matrix, '0);
    chkv("rst_left", left_matrix, '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic prev_a;
    logic v;
    logic a;
    rst      = 1'b1;
    in_valid = 1'b0;
    mat_ack  = 1'b0;
    in_data  = '0;
    do_reset();

    // Back-to-back fill with 1..32
    for (int i = 1; i <= 2 * N; i++) step(1'b1, W'(i), 1'b0);
    chk1("t1_mat_valid", mat_valid, 1'b1);
    chk1("t1_in_ready", in_ready, NB == 2);
    for (int i = 0; i < N; i++) begin
      chkw("t1_top_el", el(top_matrix, i), W'(i + 1));
      chkw("t1_left_el", el(left_matrix, i), W'(i + 17));
    end

    // Extra words while presented, then release and reload
    for (int i = 0; i < 4; i++) step(1'b1, 16'hDEAD, 1'b0);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 2 * N; i++) step(1'b1, W'(16'hA000 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Gapped stream
    do_reset();
    for (int i = 1; i <= 2 * N; i++) begin
      step(1'b1, W'(i), 1'b0);
      step(1'b0, '0, 1'b0);
    end
    for (int i = 0; i < N; i++) begin
      chkw("t2_top_el", el(top_matrix, i), W'(i + 1));
      chkw("t2_left_el", el(left_matrix, i), W'(i + 17));
    end

    // Reset mid-load discards partial data
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, W'(16'h5555 + i), 1'b0);
    do_reset();
    for (int i = 0; i < 2 * N; i++) step(1'b1, W'(100 + i), 1'b0);
    chkw("t4_top00", el(top_matrix, 0), 16'd100);
    chkw("t4_left33", el(left_matrix, N - 1), 16'd131);

    // Ack while nothing is presented, including during the left phase
    do_reset();
    step(1'b0, '0, 1'b1);
    for (int i = 1; i <= 20; i++) step(1'b1, W'(i), 1'b0);
    step(1'b1, 16'd21, 1'b1);
    for (int i = 22; i <= 2 * N; i++) step(1'b1, W'(i), 1'b0);
    chk1("t5_mat_valid", mat_valid, 1'b1);
    chkw("t5_left_last", el(left_matrix, N - 1), 16'd32);

`ifdef LOADER_DOUBLE_BUFFER_EN
    // Overlapped load of set B, acked on B's final word
    do_reset();
    for (int i = 1; i <= 2 * N; i++) step(1'b1, W'(i), 1'b0);
    for (int i = 33; i < 64; i++) step(1'b1, W'(i), 1'b0);
    chkw("t6_hold_a", el(top_matrix, 0), 16'd1);
    step(1'b1, 16'd64, 1'b1);
    chk1("t6_mat_valid", mat_valid, 1'b1);
    chk1("t6_in_ready", in_ready, 1'b1);
    chkw("t6_top00_b", el(top_matrix, 0), 16'd33);
    chkw("t6_left33_b", el(left_matrix, N - 1), 16'd64);
`endif

    // Randomized traffic with occasional single-cycle acks
    do_reset();
    prev_a = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      v = ($urandom_range(0, 99) < 70);
      a = !prev_a && ($urandom_range(0, 99) < 15);
      step(v, W'($urandom), a);
      prev_a = a;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/matmul_operand_loader.md
# matmul_operand_loader

Upstream operand-staging stage for the systolic matmul control path. It accepts operand words one per cycle over a valid/ready stream and assembles them into the flattened `top_matrix` and `left_matrix` buses consumed by `workflow_control`. It presents a complete operand set with `mat_valid` and holds it stable until the consumer returns `mat_ack`.

## Interface
Parameters:
- `WORD_SIZE`, 16, bits per matrix element.
- `ROWS`, 4, systolic array rows.
- `COLS`, 4, systolic array columns.

Ports:
- `clk`, in, 1, single clock; all state changes on its rising edge.
- `rst`, in, 1, asynchronous, active-high reset.
- `in_valid`, in, 1, `in_data` carries a word this cycle.
- `in_ready`, out, 1, loader accepts a word this cycle. A word transfers when `in_valid` and `in_ready` are both high.
- `in_data`, in, `WORD_SIZE`, operand word.
- `top_matrix`, out, `ROWS*COLS*WORD_SIZE`, top operand. Element (r,c) sits at bits `[(r*COLS+c)*WORD_SIZE +: WORD_SIZE]`.
- `left_matrix`, out, `ROWS*COLS*WORD_SIZE`, left operand, same packing.
- `mat_valid`, out, 1, complete operand set is presented.
- `mat_ack`, in, 1, consumer has finished with the presented set; single-cycle pulse.
- `loading_left`, out, 1, status: the write side is filling the left matrix.

## Operation
- Stream order, with N = ROWS*COLS:
  - N top words, row-major: (0,0), (0,1), …, (ROWS-1, COLS-1).
  - Then N left words, same order.
  - No framing signal. Position is tracked by an internal index counter `idx` (0..N-1) and a phase bit (TOP/LEFT).
- Write-side FSM has three states:
  - LOAD_TOP: each transfer writes top element `idx`. On the transfer with `idx`=N-1: `idx`→0, go to LOAD_LEFT.
  - LOAD_LEFT: each transfer writes left element `idx`. On the transfer with `idx`=N-1: `idx`→0, mark the bank full, go to FULL.
  - FULL: `in_ready`=0. Leave to LOAD_TOP when the bank is released by `mat_ack`.
- `in_ready` = (state ≠ FULL). It is decoded from registers only, with no combinational path from `in_valid`.
- `mat_valid` = bank-full flag. `top_matrix` and `left_matrix` are driven directly from the storage registers and do not change while `mat_valid`=1.
- `mat_ack` while `mat_valid`=1 clears the full flag. `mat_ack` while `mat_valid`=0 is ignored.
- `loading_left` = (state = LOAD_LEFT).
- `in_data` is stored unmodified. No arithmetic; the counter wraps exactly at N-1.

## Timing
- Reset values, applied asynchronously:
  - state = LOAD_TOP, `idx`=0, all full flags = 0, all storage = 0.
  - `in_ready`=1, `mat_valid`=0, `loading_left`=0, `top_matrix`=0, `left_matrix`=0.
- Fill latency: `mat_valid` rises in the cycle after the 2N-th accepted word. With continuous `in_valid`, that is 2N cycles after the first transfer.
- Release latency: `mat_valid` falls and `in_ready` rises in the cycle after `mat_ack`.
- Stalls: `in_valid`=0 holds `idx` and state. Gaps between words are allowed at any point.
- Reset mid-load or mid-present: all partial data is discarded. The next accepted word is top (0,0).
- Data written in cycle t appears on the output bus in cycle t+1.

## Configuration
- `LOADER_DOUBLE_BUFFER_EN` defined: two operand banks in ping-pong.
  - Write pointer `wr_bank`, read pointer `rd_bank`, per-bank full flags; all reset to bank 0 / empty.
  - `in_ready` = !full[`wr_bank`]. Completing LOAD_LEFT sets full[`wr_bank`] and toggles `wr_bank`; the FSM returns to LOAD_TOP unless the new write bank is full (then FULL).
  - `mat_valid` = full[`rd_bank`]. Outputs come from `rd_bank`. `mat_ack` clears full[`rd_bank`] and toggles `rd_bank`.
  - Fill-complete and `mat_ack` in the same cycle on different banks both take effect.
  - Loading of set k+1 overlaps presentation of set k.
- Undefined: single bank. `in_ready`=0 throughout FULL; no overlap.

## Test plan
(Default parameters, N=16.)
1. Reset, then 32 back-to-back words with values 1..32 → `mat_valid`=1 in cycle 33. `top_matrix` element (r,c) = r*4+c+1; `left_matrix` element (r,c) = r*4+c+17. `in_ready`=0 (single bank).
2. Same stream with `in_valid` toggling every other cycle → identical matrices, `mat_valid` rises one cycle after the 32nd transfer. `loading_left`=1 exactly between transfers 17 and 32.
3. With `mat_valid`=1, drive extra `in_valid` words → no transfer and outputs unchanged. Pulse `mat_ack` → `mat_valid`=0 and `in_ready`=1 next cycle. Then 32 words 0xA000+i → new matrices presented.
4. Assert `rst` after 20 accepted words, then send 32 words 100..131 → top (0,0)=100, left (3,3)=131, no stale data.
5. Pulse `mat_ack` while `mat_valid`=0 → no state change. Single bank with the pulse during LOAD_LEFT: loading continues normally.
6. `LOADER_DOUBLE_BUFFER_EN`: load set A (1..32), then immediately load set B (33..64) without ack.
   - `in_ready` stays 1 through set B; `mat_valid` holds set A.
   - Ack A in the same cycle as B's last word → next cycle shows set B, `mat_valid` stays 1, and `in_ready`=1.
